// File: rtl/pagerank_stream_reducer.sv
// Streaming lane reducer: registered adder tree feeding a group accumulator, one total + beat count per in_last group.
// Latency log2(nlanes)+2 edges, whole pipeline stalls while a result waits; `PAGERANK_REDUCER_SATURATE_EN selects saturating adds.
module pagerank_stream_reducer #(
   parameter int nbits    = 32,
   parameter int nlanes   = 4,
   parameter int cnt_bits = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_val,
   output logic                      in_rdy,
   input  logic [nlanes*nbits-1:0]   in_msg,
   input  logic                      in_last,
   output logic                      out_val,
   input  logic                      out_rdy,
   output logic [nbits-1:0]          out_msg,
   output logic [cnt_bits-1:0]       out_count
);

   localparam int L = $clog2(nlanes);
   localparam logic [cnt_bits-1:0] CNT_ONE = {{(cnt_bits-1){1'b0}}, 1'b1};

   typedef enum logic {S_FIRST, S_ACCUM} state_t;

`ifdef PAGERANK_REDUCER_SATURATE_EN
   function automatic logic [nbits-1:0] f_add(input logic [nbits-1:0] a, input logic [nbits-1:0] b);
      logic [nbits:0] s;
      s = {1'b0, a} + {1'b0, b};
      f_add = s[nbits] ? {nbits{1'b1}} : s[nbits-1:0];
   endfunction
`else
   function automatic logic [nbits-1:0] f_add(input logic [nbits-1:0] a, input logic [nbits-1:0] b);
      f_add = a + b;
   endfunction
`endif

   // Tree kept as a heap: entry n-1 holds node n, leaves (the input register) sit at nlanes-1.. .
   logic [nbits-1:0]  r_node [2*nlanes-1];
   logic [L:0]        r_vld;
   logic [L:0]        r_last;

   state_t            r_state, w_state_nxt;
   logic [nbits-1:0]  r_acc, w_acc_nxt, w_acc_new;
   logic [cnt_bits-1:0] r_cnt, w_cnt_nxt, w_cnt_new;
   logic              r_out_val, w_out_val_nxt;
   logic [nbits-1:0]  r_out_msg, w_out_msg_nxt;
   logic [cnt_bits-1:0] r_out_cnt, w_out_cnt_nxt;
   logic              w_adv;
   logic [nbits-1:0]  w_root;

   assign w_adv     = !r_out_val | out_rdy;
   assign in_rdy    = w_adv;
   assign w_root    = r_node[0];
   assign out_val   = r_out_val;
   assign out_msg   = r_out_msg;
   assign out_count = r_out_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int n = 0; n < 2*nlanes-1; n++) r_node[n] <= '0;
         r_vld  <= '0;
         r_last <= '0;
      end else if (w_adv) begin
         for (int i = 0; i < nlanes; i++) r_node[nlanes-1+i] <= in_msg[i*nbits +: nbits];
         for (int n = 1; n < nlanes; n++) r_node[n-1] <= f_add(r_node[2*n-1], r_node[2*n]);
         r_vld  <= {r_vld[L-1:0], in_val};
         r_last <= {r_last[L-1:0], in_val & in_last};
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_acc_nxt     = r_acc;
      w_cnt_nxt     = r_cnt;
      w_out_val_nxt = r_out_val;
      w_out_msg_nxt = r_out_msg;
      w_out_cnt_nxt = r_out_cnt;
      w_acc_new     = (r_state == S_FIRST) ? w_root : f_add(r_acc, w_root);
      if (r_state == S_FIRST)
         w_cnt_new = CNT_ONE;
      else
         w_cnt_new = (r_cnt == {cnt_bits{1'b1}}) ? r_cnt : r_cnt + CNT_ONE;
      // Under adv any held result has just been taken, so it drops unless replaced.
      if (w_adv) begin
         w_out_val_nxt = 1'b0;
         if (r_vld[L]) begin
            if (r_last[L]) begin
               w_out_val_nxt = 1'b1;
               w_out_msg_nxt = w_acc_new;
               w_out_cnt_nxt = w_cnt_new;
               w_acc_nxt     = '0;
               w_cnt_nxt     = '0;
               w_state_nxt   = S_FIRST;
            end else begin
               w_acc_nxt     = w_acc_new;
               w_cnt_nxt     = w_cnt_new;
               w_state_nxt   = S_ACCUM;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FIRST;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_out_val <= 1'b0;
         r_out_msg <= '0;
         r_out_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_cnt     <= w_cnt_nxt;
         r_out_val <= w_out_val_nxt;
         r_out_msg <= w_out_msg_nxt;
         r_out_cnt <= w_out_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_pagerank_stream_reducer.sv
// Randomized and directed bench for pagerank_stream_reducer against a group-sum reference model.
module tb_pagerank_stream_reducer;
   localparam int NB = 32;
   localparam int NL = 4;
   localparam int CB = 16;
   localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

   logic clk = 1'b0;
   logic reset, in_val, in_rdy, in_last, out_val, out_rdy;
   logic [NL*NB-1:0] in_msg;
   logic [NB-1:0]    out_msg;
   logic [CB-1:0]    out_count;

   pagerank_stream_reducer #(.nbits(NB), .nlanes(NL), .cnt_bits(CB)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .in_last(in_last), .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
      .out_count(out_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: true group sum and beat count, clipped once when the group closes.
   longint unsigned m_sum;
   int              m_cnt;
   longint unsigned q_sum[$];
   longint unsigned q_cnt[$];
   int              n_exp;

   function automatic longint unsigned clip_sum(input longint unsigned s);
`ifdef PAGERANK_REDUCER_SATURATE_EN
      return (s > MAXV) ? MAXV : s;
`else
      return s & MAXV;
`endif
   endfunction

   logic [NB-1:0] last_msg;
   logic [CB-1:0] last_cnt;
   int n_out, run, max_run;
   bit held;
   logic [NB-1:0] h_msg;
   logic [CB-1:0] h_cnt;
   bit rnd;

   always @(negedge clk) begin
      if (reset) begin
         held = 0;
         run  = 0;
      end else begin
         if (held) begin
            chk("stall_val", out_val, 1);
            chk("stall_msg", out_msg, h_msg);
            chk("stall_cnt", out_count, h_cnt);
         end
         held  = out_val && !out_rdy;
         h_msg = out_msg;
         h_cnt = out_count;
         if (out_val && out_rdy) begin
            run++;
            if (run > max_run) max_run = run;
            n_out++;
            last_msg = out_msg;
            last_cnt = out_count;
            if (q_sum.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               chk("out_msg", out_msg, q_sum.pop_front());
               chk("out_count", out_count, q_cnt.pop_front());
            end
         end else run = 0;
      end
   end

   always @(posedge clk) begin
      if (rnd) begin
         #1 out_rdy = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [NL*NB-1:0] msg, input logic last);
      bit ok;
      int b;
      b = 0;
      in_msg  = msg;
      in_last = last;
      in_val  = 1'b1;
      do begin
         @(negedge clk);
         ok = in_rdy;
         @(posedge clk);
         b++;
      end while (!ok && b < 500);
      if (!ok) chk("send_timeout", 0, 1);
      else begin
         for (int i = 0; i < NL; i++) m_sum += longint'(msg[i*NB +: NB]);
         m_cnt++;
         if (last) begin
            q_sum.push_back(clip_sum(m_sum));
            q_cnt.push_back((m_cnt > 65535) ? 65535 : m_cnt);
            n_exp++;
            m_sum = 0;
            m_cnt = 0;
         end
      end
      #1 in_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int b;
      b = 0;
      while (q_sum.size() != 0 && b < 300) begin
         @(posedge clk);
         b++;
      end
      chk("drain_left", q_sum.size(), 0);
      idle(2);
   endtask

   int n0;

   initial begin
      reset = 1'b1; in_val = 1'b0; in_last = 1'b0; in_msg = '0; out_rdy = 1'b1;
      m_sum = 0; m_cnt = 0; n_exp = 0; n_out = 0; run = 0; max_run = 0; held = 0; rnd = 0;
      last_msg = '0; last_cnt = '0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_val", out_val, 0);
      chk("rst_out_msg", out_msg, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_in_rdy", in_rdy, 1);
      reset = 1'b0;
      idle(1);

      // single beat, latency
      send({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("t1_lat%0d", k), out_val, (k == 3) ? 1 : 0);
      end
      chk("t1_msg", out_msg, 10);
      chk("t1_cnt", out_count, 1);
      drain();

      // three beats with a bubble
      send({4{32'd5}}, 1'b0);
      idle(1);
      send({4{32'd5}}, 1'b0);
      send({4{32'd5}}, 1'b1);
      drain();
      chk("t2_msg", last_msg, 60);
      chk("t2_cnt", last_cnt, 3);

      // backpressure
      n0 = n_out;
      out_rdy = 1'b0;
      send({4{32'd1}}, 1'b1);
      send({4{32'd2}}, 1'b1);
      idle(6);
      @(negedge clk);
      chk("t3_in_rdy", in_rdy, 0);
      chk("t3_out_val", out_val, 1);
      chk("t3_held_msg", out_msg, 4);
      idle(3);
      out_rdy = 1'b1;
      drain();
      chk("t3_n_out", n_out - n0, 2);
      chk("t3_last_msg", last_msg, 8);

      // overflow
      send({32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, 1'b1);
      drain();
`ifdef PAGERANK_REDUCER_SATURATE_EN
      chk("t4_msg", last_msg, 32'hFFFF_FFFF);
`else
      chk("t4_msg", last_msg, 0);
`endif

      // reset mid-group
      send({4{32'd3}}, 1'b0);
      send({4{32'd3}}, 1'b0);
      #2 reset = 1'b1;
      m_sum = 0;
      m_cnt = 0;
      @(negedge clk);
      chk("t5_rst_val", out_val, 0);
      chk("t5_rst_rdy", in_rdy, 1);
      @(posedge clk);
      #3 reset = 1'b0;
      n0 = n_out;
      send({4{32'd1}}, 1'b1);
      drain();
      chk("t5_msg", last_msg, 4);
      chk("t5_cnt", last_cnt, 1);
      chk("t5_n_out", n_out - n0, 1);

      // back-to-back single-beat groups
      n0 = n_out;
      max_run = 0;
      for (int i = 0; i < 5; i++) send({4{32'(i + 1)}}, 1'b1);
      drain();
      chk("t6_n_out", n_out - n0, 5);
      chk("t6_run", (max_run >= 5) ? 1 : 0, 1);
      chk("t6_last", last_msg, 20);

      // random groups under random backpressure
      rnd = 1;
      for (int g = 0; g < 40; g++) begin
         int nb;
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            logic [NL*NB-1:0] msg;
            if ($urandom_range(0, 1) == 1) msg = {$urandom, $urandom, $urandom, $urandom};
            else msg = {32'($urandom_range(0, 999)), 32'($urandom_range(0, 999)),
                        32'($urandom_range(0, 999)), 32'($urandom_range(0, 999))};
            send(msg, (b == nb - 1) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
         end
      end
      rnd = 0;
      @(posedge clk);
      #2 out_rdy = 1'b1;
      drain();
      chk("all_out", n_out, n_exp);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pagerank_stream_reducer.md
# pagerank_stream_reducer

Parametrised, pipelined streaming reducer for the pageRank datapath. Each beat carries `nlanes` unsigned words, which a registered adder tree sums. Per-beat sums are accumulated across a multi-beat group delimited by `in_last`, and one total plus a beat count is emitted per group. The block sits between the rank-contribution producers and the rank-update stage, and uses val/rdy handshakes on both sides.

## Interface
- `nbits`, 32: width of each lane, accumulator and result.
- `nlanes`, 4: words per input beat; power of two, ≥2.
- `cnt_bits`, 16: width of the group beat counter.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_val`, in, 1: input beat valid.
- `in_rdy`, out, 1: input beat accepted when `in_val & in_rdy`.
- `in_msg`, in, `nlanes*nbits`: lane i occupies bits `[i*nbits +: nbits]`.
- `in_last`, in, 1: the beat is the final beat of its group.
- `out_val`, out, 1: group result valid.
- `out_rdy`, in, 1: downstream accepts the result when `out_val & out_rdy`.
- `out_msg`, out, `nbits`: group total.
- `out_count`, out, `cnt_bits`: number of beats in the group.

## Operation
- **Tree:** L = log2(`nlanes`) levels of pairwise adders, each level registered. Each level carries a valid bit and a last bit alongside its data.
- **Accumulator stage:** acts on a valid tree-output beat.
  - First beat of a group: `acc_new = sum`, `cnt_new = 1`.
  - Otherwise: `acc_new = acc + sum`, `cnt_new = cnt + 1`.
  - If the beat's last bit is 0: `acc <= acc_new`, `cnt <= cnt_new`.
  - If the beat's last bit is 1: `out_msg <= acc_new`, `out_count <= cnt_new`, `out_val <= 1`, and acc/cnt clear to the first-of-group state.
- **Arithmetic:** unsigned, wraps modulo 2^nbits; see Configuration. `cnt` saturates at 2^cnt_bits−1.
- **Global advance:** `adv = !out_val | out_rdy`.
  - All tree registers, the accumulator and the output register update only when `adv` is 1.
  - `in_rdy = adv`, combinational.
  - A result that is not taken stalls the whole pipeline.
- **Output clear:** when `out_val & out_rdy` and no new last beat reaches the accumulator that cycle, `out_val <= 0`.
- **Accumulator states:** FIRST (no partial group) and ACCUM (partial group held).
  - FIRST→ACCUM on a non-last beat.
  - ACCUM→FIRST on a last beat.
  - A last beat arriving in FIRST (a single-beat group) stays in FIRST.
- **Bubbles:** idle cycles inside a group are allowed and leave acc/cnt unchanged.
- **Empty groups:** not expressible; every group has ≥1 beat.
- **Reset:** while `reset` is high, all valid bits, acc, cnt, `out_val`, `out_msg` and `out_count` are 0, and the state is FIRST. A partial group in flight is discarded.

## Timing
- Reset values: `out_val`=0, `out_msg`=0, `out_count`=0, `in_rdy`=1.
- Latency: a last beat accepted at edge t, with no stall, produces `out_val`=1 after edge t+L+1. This is 3 cycles for `nlanes`=4.
- Throughput: one beat per cycle while `out_rdy`=1. The output can present back-to-back results on consecutive cycles.
- Stall: while `out_val & !out_rdy`, `in_rdy`=0 and `out_msg`/`out_count` stay stable.
- Simultaneous events: if the output handshake completes and a new last beat reaches the accumulator in the same cycle, the new result is loaded and `out_val` stays 1. No result is dropped or duplicated.
- Ordering: results leave strictly in input group order.

## Configuration
- Macro: `PAGERANK_REDUCER_SATURATE_EN`.
- Defined: every tree and accumulator addition saturates at 2^nbits−1. Saturation is sticky within a group, so the group total stays at maximum.
- Undefined: all additions wrap modulo 2^nbits.
- Latency and handshake behaviour are identical in both builds.

## Test plan
All tests use `nlanes`=4 and `nbits`=32.
1. Single beat: lanes {1,2,3,4} with last=1 → `out_msg`=10, `out_count`=1, and `out_val` rises 3 cycles after acceptance.
2. Three-beat group: every lane=5, last only on beat 3, one bubble inserted between beats 1 and 2 → `out_msg`=60, `out_count`=3.
3. Backpressure: hold `out_rdy`=0 and send groups {1,1,1,1} and {2,2,2,2} → `in_rdy` falls and the first result (4) is held stable. After `out_rdy`=1, the results 4 then 8 are delivered in order.
4. Overflow: lanes {0xFFFFFFFF,1,0,0} with last=1 → `out_msg`=0 in the wrap build, and 0xFFFFFFFF with `PAGERANK_REDUCER_SATURATE_EN` defined.
5. Reset mid-group: send 2 non-last beats, assert `reset` asynchronously for 1 cycle, then send {1,1,1,1} with last=1 → `out_msg`=4, `out_count`=1, and no stale result appears.
6. Back-to-back single-beat groups with `out_rdy`=1 → `out_val` stays high for consecutive cycles and each total appears exactly once.
